// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_unit
//  Purpose  : Instruction fetch front end. It keeps one imem request in
//             flight, applies a static branch predictor, and feeds an
//             epoch-tagged FIFO toward decode.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          FQ_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        fetch_valid,
    input  logic        fetch_ready,
    output logic [31:0] fetch_inst,
    output logic [31:0] fetch_pc,
    output logic [2:0]  fetch_epoch,
    output logic        pred_taken,
    output logic [31:0] pred_target
);

    localparam int                 c_ptr_w = $clog2(FQ_DEPTH);
    localparam int                 c_cnt_w = c_ptr_w + 1;
    localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FQ_DEPTH);
    localparam logic [6:0]         c_op_jal    = 7'b1101111;
    localparam logic [6:0]         c_op_branch = 7'b1100011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DROP = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [2:0]  epoch;
        logic        taken;
        logic [31:0] target;
    } entry_t;

    state_e               state_q, state_d;
    logic [31:0]          pc_q, pc_d;
    logic [2:0]           epoch_q, epoch_d;
    logic [c_cnt_w-1:0]   count_q, count_d;
    logic [c_ptr_w-1:0]   wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]   rd_ptr_q, rd_ptr_d;
    entry_t               fq_q [FQ_DEPTH];

    logic [31:0] imm_j_w;
    logic [31:0] imm_b_w;
    logic        rsp_taken_w;
    logic [31:0] rsp_target_w;
    logic        push_w;
    logic        pop_w;
    entry_t      head_w;

    // Static predictor evaluated directly on the returning instruction word
    assign imm_j_w = {{12{imem_rsp_data[31]}}, imem_rsp_data[19:12], imem_rsp_data[20],
                      imem_rsp_data[30:21], 1'b0};
    assign imm_b_w = {{20{imem_rsp_data[31]}}, imem_rsp_data[7], imem_rsp_data[30:25],
                      imem_rsp_data[11:8], 1'b0};

    always_comb begin
        rsp_taken_w  = 1'b0;
        rsp_target_w = pc_q + 32'd4;
        if (imem_rsp_data[6:0] == c_op_jal) begin
            rsp_taken_w  = 1'b1;
            rsp_target_w = pc_q + imm_j_w;
        end else if (imem_rsp_data[6:0] == c_op_branch && imem_rsp_data[31]) begin
            rsp_taken_w  = 1'b1;
            rsp_target_w = pc_q + imm_b_w;
        end
    end

    assign imem_req_valid = !rst && (state_q == ST_IDLE) && (count_q < c_depth) && !redirect_valid;
    assign imem_req_addr  = rst ? 32'd0 : pc_q;

    assign fetch_valid = !rst && (count_q != '0);
    assign head_w      = fetch_valid ? fq_q[rd_ptr_q] : '0;
    assign fetch_inst  = head_w.inst;
    assign fetch_pc    = head_w.pc;
    assign fetch_epoch = head_w.epoch;
    assign pred_taken  = head_w.taken;
    assign pred_target = head_w.target;

    assign push_w = (state_q == ST_WAIT) && imem_rsp_valid && !redirect_valid;
    assign pop_w  = fetch_valid && fetch_ready && !redirect_valid;

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        epoch_d  = epoch_q;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (redirect_valid) begin
            pc_d     = redirect_pc;
            epoch_d  = epoch_q + 3'd1;
            count_d  = '0;
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            // A response landing with the redirect retires the only outstanding request
            case (state_q)
                ST_WAIT: state_d = imem_rsp_valid ? ST_IDLE : ST_DROP;
                ST_DROP: state_d = imem_rsp_valid ? ST_IDLE : ST_DROP;
                default: state_d = ST_IDLE;
            endcase
        end else begin
            case (state_q)
                ST_IDLE: if (imem_req_valid && imem_req_ready) state_d = ST_WAIT;
                ST_WAIT: if (imem_rsp_valid) begin
                    state_d = ST_IDLE;
                    pc_d    = rsp_target_w;
                end
                ST_DROP: if (imem_rsp_valid) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
            if (push_w) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop_w)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({push_w, pop_w})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            epoch_q  <= 3'd0;
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            epoch_q  <= epoch_d;
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && push_w) begin
            fq_q[wr_ptr_q] <= '{inst:   imem_rsp_data,
                               pc:     pc_q,
                               epoch:  epoch_q,
                               taken:  rsp_taken_w,
                               target: rsp_target_w};
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_unit
//  Purpose  : Scoreboard bench for fetch_unit with a random program and a
//             predicted-path reference stream.
//  Revision : 1.0  initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          FQ_DEPTH = 4;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        fetch_valid;
    logic        fetch_ready;
    logic [31:0] fetch_inst;
    logic [31:0] fetch_pc;
    logic [2:0]  fetch_epoch;
    logic        pred_taken;
    logic [31:0] pred_target;

    fetch_unit #(.RESET_PC(RESET_PC), .FQ_DEPTH(FQ_DEPTH)) dut (
        .clk(clk), .rst(rst),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .imem_req_valid(imem_req_valid), .imem_req_addr(imem_req_addr),
        .imem_req_ready(imem_req_ready),
        .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
        .fetch_valid(fetch_valid), .fetch_ready(fetch_ready),
        .fetch_inst(fetch_inst), .fetch_pc(fetch_pc), .fetch_epoch(fetch_epoch),
        .pred_taken(pred_taken), .pred_target(pred_target)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [2:0]  epoch;
        logic        taken;
        logic [31:0] target;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    exp_t        mon_a;
    logic [31:0] prog [256];
    logic [31:0] model_pc;
    int          model_epoch;
    int          checks = 0;
    int          failures = 0;
    int          pop_cnt = 0;

    logic        s_rst = 1'b1, s_req_fire = 1'b0, s_rsp_fire = 1'b0;
    logic [31:0] s_req_addr = '0;
    logic        hold_prev = 1'b0;
    logic [31:0] hold_addr = '0;

    int          force_lat = -1;
    logic        mem_manual = 1'b0;
    logic        manual_v = 1'b0;

    function automatic void check(input string name, input logic [127:0] act, input logic [127:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
        end
    endfunction

    // Architectural next-entry model: decode the word, sign the immediate arithmetically
    function automatic exp_t make_entry(input logic [31:0] pc);
        exp_t        e;
        logic [31:0] w;
        int          imm;
        w        = prog[pc[9:2]];
        e.inst   = w;
        e.pc     = pc;
        e.epoch  = 3'(model_epoch);
        e.taken  = 1'b0;
        e.target = pc + 32'd4;
        if (w[6:0] == 7'b1101111) begin
            imm = int'(w[30:21]) * 2 + int'(w[20]) * 2048 + int'(w[19:12]) * 4096
                  - (w[31] ? 1048576 : 0);
            e.taken  = 1'b1;
            e.target = pc + 32'(imm);
        end else if (w[6:0] == 7'b1100011 && w[31]) begin
            imm = int'(w[11:8]) * 2 + int'(w[30:25]) * 32 + int'(w[7]) * 2048 - 4096;
            e.taken  = 1'b1;
            e.target = pc + 32'(imm);
        end
        return e;
    endfunction

    function automatic void extend(input int n);
        exp_t e;
        for (int i = 0; i < n; i++) begin
            e = make_entry(model_pc);
            sb.push_back(e);
            model_pc = e.target;
        end
    endfunction

    function automatic void reseed(input logic [31:0] pc, input int ep);
        sb.delete();
        model_pc    = pc;
        model_epoch = ep;
        extend(32);
    endfunction

    // Monitor: samples at negedge, checks request hold and every handshake pop
    initial begin
        forever begin
            @(negedge clk);
            s_rst      = rst;
            s_req_fire = imem_req_valid && imem_req_ready;
            s_req_addr = imem_req_addr;
            s_rsp_fire = imem_rsp_valid;
            if (hold_prev && !rst && !redirect_valid) begin
                check("req_hold_valid", 128'(imem_req_valid), 128'(1));
                check("req_hold_addr", 128'(imem_req_addr), 128'(hold_addr));
            end
            hold_prev = !rst && imem_req_valid && !imem_req_ready;
            hold_addr = imem_req_addr;
            if (!rst && fetch_valid && fetch_ready && !redirect_valid) begin
                pop_cnt++;
                if (sb.size() == 0) begin
                    check("sb_underflow", 128'(1), 128'(0));
                end else begin
                    mon_e = sb.pop_front();
                    mon_a = '{inst: fetch_inst, pc: fetch_pc, epoch: fetch_epoch,
                              taken: pred_taken, target: pred_target};
                    check("fetch_entry", 128'(mon_a), 128'(mon_e));
                    if (sb.size() < 16) extend(32);
                end
            end
        end
    end

    // Memory: single-outstanding, in-order, latency 1..3 cycles
    initial begin
        logic        pending;
        logic [31:0] p_addr;
        int          wait_cnt;
        pending = 1'b0; p_addr = '0; wait_cnt = 0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_manual) begin
                pending        = 1'b0;
                imem_rsp_valid = manual_v;
                imem_rsp_data  = NOP;
            end else if (s_rst) begin
                pending        = 1'b0;
                imem_rsp_valid = 1'b0;
            end else begin
                if (s_rsp_fire) pending = 1'b0;
                if (s_req_fire) begin
                    pending  = 1'b1;
                    p_addr   = s_req_addr;
                    wait_cnt = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 2));
                end
                if (pending && wait_cnt == 0) begin
                    imem_rsp_valid = 1'b1;
                    imem_rsp_data  = prog[p_addr[9:2]];
                end else begin
                    imem_rsp_valid = 1'b0;
                    imem_rsp_data  = $urandom;
                    if (pending) wait_cnt--;
                end
            end
        end
    end

    task automatic do_redirect(input logic [31:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        reseed(pc, (model_epoch + 1) % 8);
        @(posedge clk);
        #1;
        redirect_valid = 1'b0;
    endtask

    task automatic wait_fire(output logic [31:0] a);
        int n = 0;
        a = '1;
        do begin
            @(negedge clk);
            n++;
        end while (!(imem_req_valid && imem_req_ready) && n < 40);
        if (imem_req_valid && imem_req_ready) a = imem_req_addr;
        else check("fire_timeout", 128'(0), 128'(1));
    endtask

    initial begin
        logic [31:0] a1, a2, w;
        int          p0, n;
        bit          found;
        rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0;
        fetch_ready = 1'b0; imem_req_ready = 1'b0;

        for (int i = 0; i < 256; i++) begin
            w = $urandom;
            case ($urandom_range(0, 9))
                0, 1, 2, 3: w = NOP;
                4, 5:       begin w[6:0] = 7'b1100011; w[8] = 1'b0; end
                6:          begin w[6:0] = 7'b1101111; w[21] = 1'b0; end
                7:          w[6:0] = 7'b1100111;
                default:    w[6:0] = 7'b0110011;
            endcase
            prog[i] = w;
        end
        for (int i = 0; i < 8; i++) prog[i] = NOP;
        prog[64]  = 32'hFE00_0EE3;
        prog[255] = NOP;
        reseed(RESET_PC, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_fetch_valid", 128'(fetch_valid), 128'(0));
        check("rst_req_valid", 128'(imem_req_valid), 128'(0));
        check("rst_head_fields", 128'({fetch_inst, fetch_pc, fetch_epoch, pred_taken, pred_target, imem_req_addr}),
              128'(0));

        @(posedge clk); #1;
        rst = 1'b0; fetch_ready = 1'b1; imem_req_ready = 1'b1;
        @(negedge clk);
        check("first_req_valid", 128'(imem_req_valid), 128'(1));
        check("first_req_addr", 128'(imem_req_addr), 128'(RESET_PC));
        repeat (20) @(posedge clk);
        #1;

        // Memory not ready for 3 cycles: request must hold
        imem_req_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        imem_req_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;

        // Decode stalled: queue fills to FQ_DEPTH and stops requesting
        force_lat = 0;
        fetch_ready = 1'b0;
        repeat (12) @(posedge clk);
        @(negedge clk);
        check("full_req_valid", 128'(imem_req_valid), 128'(0));
        check("full_fetch_valid", 128'(fetch_valid), 128'(1));
        @(posedge clk); #1;
        imem_req_ready = 1'b0;
        fetch_ready = 1'b1;
        p0 = pop_cnt; n = 0;
        do begin @(negedge clk); n++; end while (fetch_valid && n < 20);
        #1;
        check("drain_count", 128'(pop_cnt - p0), 128'(FQ_DEPTH));
        @(posedge clk); #1;
        imem_req_ready = 1'b1;
        force_lat = -1;

        // Backward branch at 0x100 predicts 0xFC
        do_redirect(32'h0000_0100);
        wait_fire(a1);
        wait_fire(a2);
        check("branch_req_addr", 128'(a1), 128'(32'h100));
        check("branch_next_addr", 128'(a2), 128'(32'hFC));
        repeat (6) @(posedge clk);
        #1;

        // Redirect while WAIT, response two cycles after acceptance
        force_lat = 1;
        wait_fire(a1);
        @(posedge clk); #1;
        do_redirect(32'h0000_0200);
        @(negedge clk);
        check("flush_empty", 128'(fetch_valid), 128'(0));
        wait_fire(a2);
        check("redirect_req_addr", 128'(a2), 128'(32'h200));
        force_lat = -1;
        repeat (8) @(posedge clk);
        #1;

        // Eight back-to-back redirects wrap the epoch
        for (int i = 0; i < 8; i++) do_redirect($urandom & 32'h0000_03FC);
        repeat (10) @(posedge clk);

        // Redirect in the same cycle as a response
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            @(posedge clk); #2;
            if (imem_rsp_valid) begin
                found = 1'b1;
                do_redirect(32'h0000_0300);
            end
        end
        check("coincident_found", 128'(found), 128'(1));
        @(negedge clk);
        check("coincident_req_valid", 128'(imem_req_valid), 128'(1));
        check("coincident_req_addr", 128'(imem_req_addr), 128'(32'h300));
        repeat (4) @(posedge clk);
        #1;

        // Mid-run reset with a late response straddling the release
        rst = 1'b1; imem_req_ready = 1'b0;
        manual_v = 1'b1; mem_manual = 1'b1;
        reseed(RESET_PC, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_req_valid", 128'(imem_req_valid), 128'(1));
        check("post_rst_req_addr", 128'(imem_req_addr), 128'(RESET_PC));
        manual_v = 1'b0;
        @(negedge clk);
        check("late_rsp_ignored", 128'(fetch_valid), 128'(0));
        mem_manual = 1'b0;
        @(posedge clk); #1;
        imem_req_ready = 1'b1;

        // Random traffic with occasional redirects, including the top-of-memory wrap
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk); #1;
            fetch_ready    = ($urandom_range(0, 3) != 0);
            imem_req_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 19) == 0) begin
                if ($urandom_range(0, 7) == 0) do_redirect(32'hFFFF_FFFC);
                else                           do_redirect($urandom & 32'hFFFF_FFFC);
            end
        end
        repeat (10) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have parameter FQ_DEPTH, default 4, meaning fetch-queue entries (power of two, >=2).
REQ-003 SHALL use one clock, clk; reset is rst, synchronous, active-high.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 redirect_valid  input  1  backend redirect (mispredict or flush).
REQ-007 redirect_pc  input  32  redirect target address.
REQ-008 imem_req_valid  output  1  instruction-memory request.
REQ-009 imem_req_addr  output  32  request address (word aligned).
REQ-010 imem_req_ready  input  1  memory accepts request.
REQ-011 imem_rsp_valid  input  1  response data valid; in-order; latency >=1 cycle.
REQ-012 imem_rsp_data  input  32  instruction word.
REQ-013 fetch_valid  output  1  queue head valid toward decode.
REQ-014 fetch_ready  input  1  decode accepts head.
REQ-015 fetch_inst  output  32  head instruction.
REQ-016 fetch_pc  output  32  head PC.
REQ-017 fetch_epoch  output  3  head epoch tag.
REQ-018 pred_taken  output  1  head static prediction.
REQ-019 pred_target  output  32  head predicted next PC.

Function
REQ-020 SHALL keep at most one imem request outstanding, tracked by an FSM with states IDLE (none outstanding), WAIT (live outstanding), DROP (stale outstanding).
REQ-021 In IDLE, imem_req_valid SHALL equal (count < FQ_DEPTH) && !redirect_valid; imem_req_addr SHALL equal pc_q.
REQ-022 Once asserted, imem_req_valid and imem_req_addr SHALL be held stable until imem_req_ready, except that redirect_valid withdraws the request in that cycle.
REQ-023 IDLE -> WAIT on imem_req_valid && imem_req_ready; imem_req_valid SHALL be 0 in WAIT and DROP.
REQ-024 WAIT with imem_rsp_valid and no redirect: push {imem_rsp_data, pc_q, epoch_q, pred} into the queue; pc_q <= predicted next PC; -> IDLE.
REQ-025 Static predictor on the response: JAL (opcode 1101111) taken, target pc+imm_j; branch (1100011) with inst[31]=1 taken, target pc+imm_b; all others, including JALR, not taken, target pc+4.
REQ-026 Address arithmetic SHALL be 32-bit modulo 2^32 (32'hFFFF_FFFC+4 = 0).
REQ-027 redirect_valid in any state: pc_q <= redirect_pc; epoch_q <= epoch_q+1 (3-bit wrap, 7->0); queue count <= 0; no push and no pop that cycle.
REQ-028 On redirect in WAIT: if imem_rsp_valid in the same cycle, discard it -> IDLE; otherwise -> DROP.
REQ-029 In DROP, imem_rsp_valid SHALL be discarded -> IDLE; a further redirect in DROP stays DROP.
REQ-030 fetch_valid SHALL equal (count != 0); head fields SHALL be driven from the queue head entry.
REQ-031 Pop SHALL occur on fetch_valid && fetch_ready && !redirect_valid.
REQ-032 Push and pop in the same cycle SHALL leave count unchanged; push never occurs when full (credit check at issue).
REQ-033 fetch_epoch SHALL carry the epoch current when the request was issued; entries pushed after a redirect carry the incremented epoch.
REQ-034 Queue order SHALL be strict FIFO; read and write pointers wrap modulo FQ_DEPTH.

Reset
REQ-035 While rst=1: pc_q=RESET_PC, epoch_q=0, count=0, FSM=IDLE, fetch_valid=0, imem_req_valid=0; all other outputs SHALL be 0.
REQ-036 rst asserted mid-operation SHALL abandon any outstanding request; a late imem_rsp_valid after reset SHALL be ignored until a new request is issued.
REQ-037 The first request SHALL assert in the first cycle after rst deasserts, addr=RESET_PC.

Verification
REQ-038 Reset release, ready=1, 1-cycle memory returning NOPs -> addrs 0,4,8,... in order; fetch_pc 0,4,8; epoch 0; pred_taken 0.
REQ-039 Word 0xFE000EE3 (beq backward, imm -4) at pc 0x100 -> pred_taken=1, pred_target=0xFC, next imem_req_addr=0xFC.
REQ-040 Redirect to 0x200 while in WAIT, response 2 cycles later -> response dropped, next request addr 0x200, entry epoch 1, queue empty after redirect.
REQ-041 fetch_ready=0 for 10 cycles -> exactly FQ_DEPTH entries queued, imem_req_valid=0 while full; resume drains in order with no loss.
REQ-042 8 redirects -> epoch wraps 7->0; redirect coincident with rsp_valid -> response discarded, FSM IDLE.
REQ-043 imem_req_ready=0 for 3 cycles -> imem_req_valid and addr held stable throughout.
